// File: rtl/dmem_sram_frontend.sv
// Front end between a data-memory adapter and a single-port SRAM macro:
// zero-fills the macro after reset, then passes accesses through and holds read data.
module dmem_sram_frontend #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int InitEn = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csb_i,
  input  logic            web_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wmask_i,
  output logic [DW-1:0]   rdata_o,
  output logic            init_done_o,
  output logic            err_o,
  output logic            csb_o,
  output logic            web_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   din_o,
  output logic [DW/8-1:0] wmask_o,
  input  logic [DW-1:0]   dout_i,
  output logic            dbg_state_o
);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam state_t        RST_STATE = (InitEn != 0) ? INIT : READY;
  localparam logic [AW-1:0] CNT_ONE   = AW'(1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          rd_pend;
  logic [DW-1:0] hold;

  // init_done_o is the gate for adapter traffic, so a cycle is accepted only
  // once the flop already shows 1; the transition cycle itself is still dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RST_STATE;
      cnt         <= '0;
      init_done_o <= 1'b0;
      err_o       <= 1'b0;
      rd_pend     <= 1'b0;
      hold        <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + CNT_ONE;
          if (&cnt) begin
            state       <= READY;
            init_done_o <= 1'b1;
          end
        end
        READY:   init_done_o <= 1'b1;
        default: state <= RST_STATE;
      endcase
      if (!csb_i && !init_done_o) err_o <= 1'b1;
      rd_pend <= init_done_o && !csb_i && web_i;
      if (rd_pend) hold <= dout_i;
    end
  end

  // Macro side: deselected in reset, fill writes in INIT, zero-latency pass-through after.
  always_comb begin
    csb_o   = 1'b1;
    web_o   = 1'b1;
    addr_o  = '0;
    din_o   = '0;
    wmask_o = '0;
    if (!rst_i) begin
      if (state == INIT) begin
        csb_o   = 1'b0;
        web_o   = 1'b0;
        addr_o  = cnt;
        wmask_o = '1;
      end else if (init_done_o) begin
        csb_o   = csb_i;
        web_o   = web_i;
        addr_o  = addr_i;
        din_o   = wdata_i;
        wmask_o = wmask_i;
      end
    end
  end

  assign rdata_o     = rd_pend ? dout_i : hold;
  assign dbg_state_o = (state == READY);

endmodule

// File: tb/tb_dmem_sram_frontend.sv
// Directed bench for dmem_sram_frontend: one instance with zero-fill enabled,
// one with it disabled, against a behavioural SRAM macro model.
module tb_dmem_sram_frontend;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, csb, web;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [MW-1:0] wmask;
  logic [DW-1:0] rdata, m_din, m_dout;
  logic          init_done, err, m_csb, m_web, dbg_state;
  logic [AW-1:0] m_addr;
  logic [MW-1:0] m_wmask;

  logic          b_rst, b_csb, b_web;
  logic [AW-1:0] b_addr, b_m_addr;
  logic [DW-1:0] b_rdata, b_m_din;
  logic [DW-1:0] b_dout = 32'h5A5A0007;
  logic          b_init_done, b_err, b_m_csb, b_m_web, b_dbg_state;
  logic [MW-1:0] b_m_wmask;

  dmem_sram_frontend #(.AW(AW), .DW(DW), .InitEn(1)) dut (
    .clk_i(clk), .rst_i(rst), .csb_i(csb), .web_i(web), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata), .init_done_o(init_done),
    .err_o(err), .csb_o(m_csb), .web_o(m_web), .addr_o(m_addr), .din_o(m_din),
    .wmask_o(m_wmask), .dout_i(m_dout), .dbg_state_o(dbg_state)
  );

  dmem_sram_frontend #(.AW(AW), .DW(DW), .InitEn(0)) dut_noinit (
    .clk_i(clk), .rst_i(b_rst), .csb_i(b_csb), .web_i(b_web), .addr_i(b_addr),
    .wdata_i(32'h0), .wmask_i(4'h0), .rdata_o(b_rdata), .init_done_o(b_init_done),
    .err_o(b_err), .csb_o(b_m_csb), .web_o(b_m_web), .addr_o(b_m_addr), .din_o(b_m_din),
    .wmask_o(b_m_wmask), .dout_i(b_dout), .dbg_state_o(b_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SRAM macro model; fill writes are checked for order, data and mask.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            fill_mon = 1'b0;
  int            fill_writes = 0;
  int            seq_err = 0;
  logic [AW-1:0] exp_fill = '0;

  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A5A5A5;

  always @(posedge clk) begin
    if (!m_csb) begin
      if (!m_web) begin
        if (fill_mon) begin
          if (m_addr !== exp_fill || m_din !== '0 || m_wmask !== '1) seq_err++;
          exp_fill++;
          fill_writes++;
        end
        for (int b = 0; b < MW; b++)
          if (m_wmask[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
      end else begin
        m_dout <= mem[m_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb = 1'b1; web = 1'b1; addr = '0; wdata = '0; wmask = '0;
  endtask

  task automatic arm_fill_monitor();
    fill_mon = 1'b1; fill_writes = 0; seq_err = 0; exp_fill = '0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    csb = 1'b0; web = 1'b0; addr = a; wdata = d; wmask = m;
    tick();
    idle();
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    csb = 1'b0; web = 1'b1; addr = a;
    exp_q.push_back(exp);
    tick();
    idle();
    check(tag, rdata, exp_q.pop_front());
  endtask

  int            cycles;
  logic          err_pre;
  logic [DW-1:0] rd_before;

  initial begin
    rst = 1'b1; b_rst = 1'b1; idle();
    b_csb = 1'b1; b_web = 1'b1; b_addr = '0;
    tick(); tick();

    check("rst_csb_o", 32'(m_csb), 32'h1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_noinit_done", 32'(b_init_done), 32'h0);

    // Instance without fill: ready on the first edge after release.
    b_rst = 1'b0;
    tick();
    check("noinit_done_first_edge", 32'(b_init_done), 32'h1);
    b_csb = 1'b0; b_web = 1'b1; b_addr = 12'h7A3;
    #1;
    check("noinit_pass_csb", 32'(b_m_csb), 32'h0);
    check("noinit_pass_web", 32'(b_m_web), 32'h1);
    check("noinit_pass_addr", 32'(b_m_addr), 32'h7A3);
    tick();
    check("noinit_read_data", b_rdata, 32'h5A5A0007);
    b_csb = 1'b1;

    // Clean fill, with an adapter write landing on the INIT-to-READY cycle.
    arm_fill_monitor();
    rst = 1'b0;
    #1;
    check("fill_first_addr", 32'(m_addr), 32'h0);
    check("fill_first_csb", 32'(m_csb), 32'h0);
    cycles = 0; err_pre = 1'b1;
    while (!init_done && cycles < 5000) begin
      if (cycles == 4095) begin
        err_pre = err;
        csb = 1'b0; web = 1'b0; addr = 12'h005; wdata = '1; wmask = '1;
      end else begin
        idle();
      end
      tick();
      cycles++;
    end
    idle();
    fill_mon = 1'b0;
    check("fill_cycles", 32'(cycles), 32'd4096);
    check("fill_writes", 32'(fill_writes), 32'd4096);
    check("fill_order", 32'(seq_err), 32'h0);
    check("fill_err_clean", 32'(err_pre), 32'h0);
    check("edge_access_err", 32'(err), 32'h1);
    check("ready_state", 32'(dbg_state), 32'h1);

    // READY-phase function.
    csb = 1'b0; web = 1'b0; addr = 12'h010; wdata = 32'hDEADBEEF; wmask = 4'b0101;
    #1;
    check("pass_addr", 32'(m_addr), 32'h010);
    check("pass_din", m_din, 32'hDEADBEEF);
    check("pass_wmask", 32'(m_wmask), 32'h5);
    check("pass_web", 32'(m_web), 32'h0);
    tick();
    idle();
    read_check("masked_write_read", 12'h010, 32'h00AD00EF);
    rd_before = rdata;
    write_word(12'h020, 32'hFFFFFFFF, 4'hF);
    tick();
    check("write_keeps_rdata", rdata, rd_before);
    read_check("edge_write_dropped", 12'h005, 32'h0);
    read_check("last_fill_word", 12'hFFF, 32'h0);

    write_word(12'h001, 32'h11111111, 4'hF);
    write_word(12'h002, 32'h22222222, 4'hF);
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h22222222);
    csb = 1'b0; web = 1'b1; addr = 12'h001;
    tick();
    check("b2b_first", rdata, exp_q.pop_front());
    addr = 12'h002;
    tick();
    idle();
    check("b2b_second", rdata, exp_q.pop_front());
    tick();
    check("b2b_hold1", rdata, exp_q.pop_front());
    tick();
    check("b2b_hold2", rdata, exp_q.pop_front());

    csb = 1'b0; web = 1'b0; addr = 12'h003; wdata = 32'hCAFEF00D; wmask = 4'hF;
    tick();
    web = 1'b1;
    tick();
    idle();
    check("read_after_write", rdata, 32'hCAFEF00D);

    // Reset while a read is pending, then a fill interrupted at cycle 2000.
    csb = 1'b0; web = 1'b1; addr = 12'h001;
    tick();
    idle();
    rst = 1'b1;
    arm_fill_monitor();
    #1;
    check("midread_rst_rdata", rdata, 32'h0);
    check("midread_rst_csb", 32'(m_csb), 32'h1);
    tick();
    rst = 1'b0;
    #1;
    check("midread_rel_rdata", rdata, 32'h0);
    check("rst_clears_err", 32'(err), 32'h0);
    repeat (2000) tick();
    rst = 1'b1;
    arm_fill_monitor();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("refill_addr_zero", 32'(m_addr), 32'h0);
    check("refill_state", 32'(dbg_state), 32'h0);

    cycles = 0;
    while (!init_done && cycles < 5000) begin
      if (cycles == 100) begin
        csb = 1'b0; web = 1'b1; addr = 12'h123;
      end else begin
        idle();
      end
      tick();
      cycles++;
      if (cycles == 101) check("init_drop_err", 32'(err), 32'h1);
      if (cycles == 102) check("init_drop_rdata", rdata, 32'h0);
    end
    idle();
    fill_mon = 1'b0;
    check("refill_cycles", 32'(cycles), 32'd4096);
    check("refill_writes", 32'(fill_writes), 32'd4096);
    check("refill_order", 32'(seq_err), 32'h0);
    check("err_sticky", 32'(err), 32'h1);
    check("refill_rdata", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
